// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

    localparam int WORD_W       = 16;
    localparam int DMEM_DEPTH   = 32;
    localparam int DMEM_LATENCY = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

endpackage

// File: rtl/dmem_array.sv
// Word array: synchronous write, combinational read, contents survive reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter  int DEPTH = DMEM_DEPTH,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [WORD_W-1:0] wd,
    output logic [WORD_W-1:0] rd
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[idx] <= wd;
    end

    assign rd = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data memory responder: one request at a time, LATENCY wait states.
// Define DMEM_ERR_EN to add misaligned/out-of-range fault reporting on rsp_err.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter  int DEPTH   = DMEM_DEPTH,
    parameter  int LATENCY = DMEM_LATENCY,
    localparam int IDX_W   = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_rdata
`ifdef DMEM_ERR_EN
    ,
    output logic        rsp_err
`endif
);

    state_t             state, state_nxt;
    logic [3:0]         cnt;
    logic               wr_q;
    logic [15:0]        addr_q;
    logic [15:0]        wdata_q;
    logic               fault;
    logic               arr_we;
    logic [IDX_W-1:0]   idx;
    logic [WORD_W-1:0]  arr_rd;

    assign idx = addr_q[IDX_W:1];

`ifdef DMEM_ERR_EN
    assign fault = addr_q[0] | ({1'b0, addr_q[15:1]} >= 16'(DEPTH));
`else
    // Without fault checking, high address bits and bit 0 simply wrap/ignore.
    logic unused_addr;
    assign unused_addr = ^addr_q;
    assign fault       = 1'b0;
`endif

    // Write lands at the end of ACCESS even if reset is asserted that cycle.
    assign arr_we = (state == ACCESS) && wr_q && !fault;

    dmem_array #(.DEPTH(DEPTH)) u_array (
        .clk (clk),
        .we  (arr_we),
        .idx (idx),
        .wd  (wdata_q),
        .rd  (arr_rd)
    );

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        case (state)
            IDLE: begin
                req_ready = reset;
                if (req_valid) state_nxt = (LATENCY > 0) ? WAIT : ACCESS;
            end
            WAIT:    if (cnt == 4'd0) state_nxt = ACCESS;
            ACCESS:  state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            wr_q      <= 1'b0;
            addr_q    <= 16'd0;
            wdata_q   <= 16'd0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 16'd0;
`ifdef DMEM_ERR_EN
            rsp_err   <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (req_valid) begin
                    wr_q    <= req_write;
                    addr_q  <= req_addr;
                    wdata_q <= req_wdata;
                    cnt     <= (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
                end
                WAIT: if (cnt != 4'd0) cnt <= cnt - 4'd1;
                ACCESS: begin
                    rsp_valid <= 1'b1;
                    rsp_rdata <= fault ? 16'd0 : (wr_q ? wdata_q : arr_rd);
`ifdef DMEM_ERR_EN
                    rsp_err   <= fault;
`endif
                end
                RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
`ifdef DMEM_ERR_EN
                    rsp_err   <= 1'b0;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: LATENCY=2 and LATENCY=0 instances against a word-array model.
module tb_dmem_responder;

    localparam int DEPTH = 32;
`ifdef DMEM_ERR_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_write = 1'b0;
    logic [15:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        rsp_ready = 1'b0;
    logic        rv2 = 1'b0, rv0 = 1'b0;
    logic        rr2, rr0, vl2, vl0;
    logic [15:0] rd2, rd0;
    logic        er2, er0;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    bit          sel = 1'b0;    // 0 = LATENCY 2 instance, 1 = LATENCY 0 instance
    bit          b2b = 1'b0;
    bit          have_last = 1'b0;
    int          last_acc = 0;
    logic [15:0] m2 [DEPTH];
    logic [15:0] m0 [DEPTH];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(2)) dut (
        .clk(clk), .reset(reset), .req_valid(rv2), .req_ready(rr2),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(vl2), .rsp_ready(rsp_ready), .rsp_rdata(rd2)
`ifdef DMEM_ERR_EN
        , .rsp_err(er2)
`endif
    );

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(0)) dut0 (
        .clk(clk), .reset(reset), .req_valid(rv0), .req_ready(rr0),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(vl0), .rsp_ready(rsp_ready), .rsp_rdata(rd0)
`ifdef DMEM_ERR_EN
        , .rsp_err(er0)
`endif
    );

`ifndef DMEM_ERR_EN
    assign er2 = 1'b0;
    assign er0 = 1'b0;
`endif

    wire        o_ready = sel ? rr0 : rr2;
    wire        o_valid = sel ? vl0 : vl2;
    wire [15:0] o_rdata = sel ? rd0 : rd2;
    wire        o_err   = sel ? er0 : er2;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_fault(input logic [15:0] a);
        return ERR && ((a % 2) == 1 || (a / 2) >= DEPTH);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction on the selected instance; entered and left at posedge+1.
    task automatic txn(input bit w, input logic [15:0] a, input logic [15:0] d, input int dly);
        int n;
        int lat;
        int acc;
        int idx;
        bit f;
        logic [15:0] exp;
        idx = (a / 2) % DEPTH;
        f   = is_fault(a);
        if (f)      exp = 16'h0;
        else if (w) exp = d;
        else        exp = sel ? m0[idx] : m2[idx];
        if (w && !f) begin
            if (sel) m0[idx] = d; else m2[idx] = d;
        end
        req_write = w; req_addr = a; req_wdata = d;
        if (sel) rv0 = 1'b1; else rv2 = 1'b1;
        n = 0;
        while (!o_ready && n < 20) begin tick(); n++; end
        check("req_ready_before_accept", o_ready, 1);
        tick();
        acc = cyc;
        rv0 = 1'b0; rv2 = 1'b0;
        if (b2b && have_last) check("b2b_gap", acc - last_acc, 3);
        have_last = 1'b1;
        last_acc  = acc;
        lat = 0;
        while (!o_valid && lat < 20) begin tick(); lat++; end
        check("latency", lat, sel ? 1 : 3);
        check("rdata", o_rdata, exp);
        check("err", o_err, ERR ? f : 1'b0);
        for (int k = 0; k < dly; k++) begin
            tick();
            check("hold_valid", o_valid, 1);
            check("hold_rdata", o_rdata, exp);
            check("hold_ready_low", o_ready, 0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("valid_cleared", o_valid, 0);
        check("ready_after_hs", o_ready, 1);
        check("err_cleared", o_err, 0);
    endtask

    initial begin
        logic [15:0] a;
        // Reset state
        reset = 1'b0;
        repeat (3) tick();
        check("rst_valid2", vl2, 0);
        check("rst_rdata2", rd2, 0);
        check("rst_ready2", rr2, 0);
        check("rst_valid0", vl0, 0);
        check("rst_ready0", rr0, 0);
        check("rst_err2", er2, 0);
        reset = 1'b1;
        tick();
        check("idle_ready2", rr2, 1);
        check("idle_ready0", rr0, 1);

        // Fill both arrays so every later load has a known value
        for (int s = 0; s < 2; s++) begin
            sel = bit'(s);
            for (int i = 0; i < DEPTH; i++) txn(1'b1, 16'(i * 2), 16'($urandom), 0);
        end

        // Store then load, LATENCY 2
        sel = 1'b0;
        txn(1'b1, 16'h0004, 16'hBEEF, 0);
        txn(1'b0, 16'h0004, 16'h0000, 0);
        // Backpressure on a load
        txn(1'b0, 16'h0004, 16'h0000, 5);

        // Reset during WAIT drops a pending store
        txn(1'b1, 16'h0010, 16'h0000, 0);
        req_write = 1'b1; req_addr = 16'h0010; req_wdata = 16'h1234; rv2 = 1'b1;
        tick();
        rv2 = 1'b0;
        reset = 1'b0;
        tick();
        check("midwait_valid", vl2, 0);
        check("midwait_rdata", rd2, 0);
        reset = 1'b1;
        tick();
        check("midwait_idle_ready", rr2, 1);
        check("midwait_idle_valid", vl2, 0);
        txn(1'b0, 16'h0010, 16'h0000, 1);

        // Wrap/ignore or fault behaviour on odd and out-of-range addresses
        for (int s = 0; s < 2; s++) begin
            sel = bit'(s);
            txn(1'b0, 16'h0042, 16'h0000, 0);
            txn(1'b1, 16'h0005, 16'hA5A5, 0);
            txn(1'b0, 16'h0004, 16'h0000, 0);
            txn(1'b0, 16'h0040, 16'h0000, 0);
            txn(1'b0, 16'h003E, 16'h0000, 0);
        end

        // Back-to-back on LATENCY 0: one transaction per 3 cycles
        sel = 1'b1; b2b = 1'b1; have_last = 1'b0;
        for (int i = 0; i < 6; i++) txn(i[0], 16'(i * 6), 16'($urandom), 0);
        b2b = 1'b0;

        // Random mix on both instances
        for (int i = 0; i < 60; i++) begin
            sel = bit'(i % 2);
            a = 16'($urandom_range(0, 127));
            txn(1'($urandom), a, 16'($urandom), int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
